// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encodings and default width for the Booth multiplier
package booth_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_paso.sv
// rtl/booth_paso.sv - one combinational radix-2 Booth step: add/sub/no-op then arithmetic shift right
module booth_paso #(
  parameter int N = 4
) (
  input  logic [N:0]   a_i,
  input  logic [N-1:0] qr_i,
  input  logic         q1_i,
  input  logic [N:0]   mr_i,
  output logic [N:0]   a_o,
  output logic [N-1:0] qr_o,
  output logic         q1_o
);

  logic [N:0] t;

  always_comb begin
    case ({qr_i[0], q1_i})
      2'b01:   t = a_i + mr_i;
      2'b10:   t = a_i - mr_i;
      default: t = a_i;
    endcase
  end

  assign a_o  = {t[N], t[N:1]};
  assign qr_o = {t[0], qr_i[N-1:1]};
  assign q1_o = qr_i[0];

endmodule

// File: rtl/booth_secuencial.sv
// rtl/booth_secuencial.sv - sequential signed Booth multiplier, one iteration per clock, start/busy/done handshake
module booth_secuencial
  import booth_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           CLK,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_e state_q, state_d;

  logic [N:0]     a_q, mr_q, a_nx;
  logic [N-1:0]   qr_q, qr_nx;
  logic           q1_q, q1_nx;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] p_q;

  booth_paso #(.N(N)) u_paso (
    .a_i  (a_q),
    .qr_i (qr_q),
    .q1_i (q1_q),
    .mr_i (mr_q),
    .a_o  (a_nx),
    .qr_o (qr_nx),
    .q1_o (q1_nx)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = start ? ST_CALC : ST_IDLE;
      ST_CALC: state_d = (cnt_q == CNT_ONE) ? ST_DONE : ST_CALC;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_CALC: busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured at start so input changes during CALC are harmless.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      mr_q  <= '0;
      qr_q  <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q   <= '0;
            qr_q  <= Q;
            q1_q  <= 1'b0;
            mr_q  <= {M[N-1], M};
            cnt_q <= CNT_N;
          end
        end
        ST_CALC: begin
          a_q   <= a_nx;
          qr_q  <= qr_nx;
          q1_q  <= q1_nx;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) p_q <= {a_nx[N-1:0], qr_nx};
        end
        ST_DONE: ;
        default: begin
          a_q   <= '0;
          mr_q  <= '0;
          qr_q  <= '0;
          q1_q  <= 1'b0;
          cnt_q <= '0;
          p_q   <= '0;
        end
      endcase
    end
  end

  assign P = p_q;

endmodule
